// File: rtl/rop_stencil_pipe.sv
// rop_stencil_pipe -- multi-lane stencil test-and-update pipeline for the ROP back end.
//
// Each lane compares (sref & read_mask) against (val & read_mask) using the
// selected compare function. The compare result and depth_pass pick one of the
// sfail/zfail/zpass ops. The op result is merged into the stored value under
// write_mask. There are two register stages (p0, p1) with a valid/ready
// handshake on both sides.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   valid_in / ready_in        input handshake
//   func, sfail_op, zfail_op, zpass_op, sref, read_mask, write_mask,
//   lane_mask, depth_pass, val, tag_in   transaction fields
//   valid_out / ready_out      output handshake
//   result, stencil_pass, lane_mask_out, tag_out   registered outputs
//
// Optional build macro ROP_STENCIL_STATS_EN:
//   adds perf_pass_count / perf_fail_count. These counters accumulate the
//   number of active lanes that pass or fail the test on each output fire.
module rop_stencil_pipe #(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 8,
  parameter int TAGW      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [2:0]                 func,
  input  logic [2:0]                 sfail_op,
  input  logic [2:0]                 zfail_op,
  input  logic [2:0]                 zpass_op,
  input  logic [DATAW-1:0]           sref,
  input  logic [DATAW-1:0]           read_mask,
  input  logic [DATAW-1:0]           write_mask,
  input  logic [NUM_LANES-1:0]       lane_mask,
  input  logic [NUM_LANES-1:0]       depth_pass,
  input  logic [NUM_LANES*DATAW-1:0] val,
  input  logic [TAGW-1:0]            tag_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [NUM_LANES*DATAW-1:0] result,
  output logic [NUM_LANES-1:0]       stencil_pass,
  output logic [NUM_LANES-1:0]       lane_mask_out,
  output logic [TAGW-1:0]            tag_out
`ifdef ROP_STENCIL_STATS_EN
  ,
  output logic [31:0]                perf_pass_count,
  output logic [31:0]                perf_fail_count
`endif
);

  localparam logic [2:0] OP_KEEP      = 3'd0;
  localparam logic [2:0] OP_ZERO      = 3'd1;
  localparam logic [2:0] OP_REPLACE   = 3'd2;
  localparam logic [2:0] OP_INCR      = 3'd3;
  localparam logic [2:0] OP_DECR      = 3'd4;
  localparam logic [2:0] OP_INVERT    = 3'd5;
  localparam logic [2:0] OP_INCR_WRAP = 3'd6;

  // Compare with a = masked reference and b = masked stored value, both unsigned.
  function automatic logic stencil_cmp(input logic [2:0] f,
                                       input logic [DATAW-1:0] a,
                                       input logic [DATAW-1:0] b);
    logic r;
    case (f)
      3'd0:    r = 1'b0;
      3'd1:    r = (a <  b);
      3'd2:    r = (a == b);
      3'd3:    r = (a <= b);
      3'd4:    r = (a >  b);
      3'd5:    r = (a != b);
      3'd6:    r = (a >= b);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [DATAW-1:0] incr_sat(input logic [DATAW-1:0] v);
    return (&v) ? v : v + DATAW'(1);
  endfunction

  function automatic logic [DATAW-1:0] decr_sat(input logic [DATAW-1:0] v);
    return (v == '0) ? v : v - DATAW'(1);
  endfunction

  function automatic logic [DATAW-1:0] apply_op(input logic [2:0] op,
                                                input logic [DATAW-1:0] v,
                                                input logic [DATAW-1:0] r);
    logic [DATAW-1:0] n;
    case (op)
      OP_KEEP:      n = v;
      OP_ZERO:      n = '0;
      OP_REPLACE:   n = r;
      OP_INCR:      n = incr_sat(v);
      OP_DECR:      n = decr_sat(v);
      OP_INVERT:    n = ~v;
      OP_INCR_WRAP: n = v + DATAW'(1);
      default:      n = v - DATAW'(1);
    endcase
    return n;
  endfunction

`ifdef ROP_STENCIL_STATS_EN
  function automatic logic [31:0] pop_count(input logic [NUM_LANES-1:0] b);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < NUM_LANES; i++) c = c + 32'(b[i]);
    return c;
  endfunction
`endif

  logic vld_p0, vld_p1;
  logic adv_p0, adv_p1;

  assign adv_p1   = !vld_p1 || ready_out;
  assign adv_p0   = !vld_p0 || adv_p1;
  assign ready_in = adv_p0;

  // ---- input side: per-lane compare feeding p0 ----
  logic [NUM_LANES-1:0] pass_c;

  always_comb begin
    pass_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      pass_c[i] = stencil_cmp(func, sref & read_mask, val[i*DATAW +: DATAW] & read_mask);
  end

  logic [2:0]                 sfail_p0, zfail_p0, zpass_p0;
  logic [DATAW-1:0]           sref_p0, wmask_p0;
  logic [NUM_LANES-1:0]       lmask_p0, dpass_p0, pass_p0;
  logic [NUM_LANES*DATAW-1:0] val_p0;
  logic [TAGW-1:0]            tag_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p0 <= 1'b0;
    else if (adv_p0) vld_p0 <= valid_in;
  end

  always_ff @(posedge clk) begin
    if (adv_p0 && valid_in) begin
      sfail_p0 <= sfail_op;
      zfail_p0 <= zfail_op;
      zpass_p0 <= zpass_op;
      sref_p0  <= sref;
      wmask_p0 <= write_mask;
      lmask_p0 <= lane_mask;
      dpass_p0 <= depth_pass;
      pass_p0  <= pass_c;
      val_p0   <= val;
      tag_p0   <= tag_in;
    end
  end

  // ---- p0 -> p1: op select, op apply and write-mask merge ----
  logic [NUM_LANES*DATAW-1:0] res_c;
  logic [NUM_LANES-1:0]       sp_c;
  logic [DATAW-1:0]           lane_v, lane_n;
  logic [2:0]                 lane_op;

  always_comb begin
    res_c   = val_p0;
    sp_c    = '0;
    lane_v  = '0;
    lane_n  = '0;
    lane_op = OP_KEEP;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_v = val_p0[i*DATAW +: DATAW];
      if (lmask_p0[i]) begin
        if (!pass_p0[i])       lane_op = sfail_p0;
        else if (!dpass_p0[i]) lane_op = zfail_p0;
        else                   lane_op = zpass_p0;
        lane_n = apply_op(lane_op, lane_v, sref_p0);
        res_c[i*DATAW +: DATAW] = (lane_n & wmask_p0) | (lane_v & ~wmask_p0);
        sp_c[i] = pass_p0[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      result        <= '0;
      stencil_pass  <= '0;
      lane_mask_out <= '0;
      tag_out       <= '0;
    end else if (adv_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        result        <= res_c;
        stencil_pass  <= sp_c;
        lane_mask_out <= lmask_p0;
        tag_out       <= tag_p0;
      end
    end
  end

  assign valid_out = vld_p1;

`ifdef ROP_STENCIL_STATS_EN
  // stencil_pass is already zero on inactive lanes, so only fails need the lane mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_pass_count <= '0;
      perf_fail_count <= '0;
    end else if (vld_p1 && ready_out) begin
      perf_pass_count <= perf_pass_count + pop_count(stencil_pass);
      perf_fail_count <= perf_fail_count + pop_count(lane_mask_out & ~stencil_pass);
    end
  end
`endif

endmodule

// File: tb/tb_rop_stencil_pipe.sv
// Directed testbench for rop_stencil_pipe.
// It uses NUM_LANES=4, DATAW=8 and TAGW=8.
module tb_rop_stencil_pipe;
  localparam int NL = 4;
  localparam int DW = 8;
  localparam int TW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic             ready_in;
  logic [2:0]       func, sfail_op, zfail_op, zpass_op;
  logic [DW-1:0]    sref, read_mask, write_mask;
  logic [NL-1:0]    lane_mask, depth_pass;
  logic [NL*DW-1:0] val;
  logic [TW-1:0]    tag_in;
  logic             valid_out;
  logic             ready_out;
  logic [NL*DW-1:0] result;
  logic [NL-1:0]    stencil_pass, lane_mask_out;
  logic [TW-1:0]    tag_out;
`ifdef ROP_STENCIL_STATS_EN
  logic [31:0]      perf_pass_count, perf_fail_count;
`endif

  always #5 clk = ~clk;

  rop_stencil_pipe #(.NUM_LANES(NL), .DATAW(DW), .TAGW(TW)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .func          (func),
    .sfail_op      (sfail_op),
    .zfail_op      (zfail_op),
    .zpass_op      (zpass_op),
    .sref          (sref),
    .read_mask     (read_mask),
    .write_mask    (write_mask),
    .lane_mask     (lane_mask),
    .depth_pass    (depth_pass),
    .val           (val),
    .tag_in        (tag_in),
    .valid_out     (valid_out),
    .ready_out     (ready_out),
    .result        (result),
    .stencil_pass  (stencil_pass),
    .lane_mask_out (lane_mask_out),
    .tag_out       (tag_out)
`ifdef ROP_STENCIL_STATS_EN
    ,
    .perf_pass_count (perf_pass_count),
    .perf_fail_count (perf_fail_count)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [TW-1:0] vtag = 8'h40;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The caller enters #1 after a posedge with ready_out=1 and the pipe flowing.
  // A single transaction must appear exactly two edges later.
  task automatic run_vec(input string tag, input logic [2:0] f,
                         input logic [2:0] sf, input logic [2:0] zf, input logic [2:0] zp,
                         input logic [7:0] sr, input logic [7:0] rm, input logic [7:0] wm,
                         input logic [3:0] lm, input logic [3:0] dp, input logic [31:0] v,
                         input logic [31:0] exp_res, input logic [3:0] exp_sp);
    logic [TW-1:0] t;
    vtag = vtag + 8'd1;
    t = vtag;
    func = f; sfail_op = sf; zfail_op = zf; zpass_op = zp;
    sref = sr; read_mask = rm; write_mask = wm;
    lane_mask = lm; depth_pass = dp; val = v; tag_in = t;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check({tag, "_lat1"}, {63'd0, valid_out}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_vld"}, {63'd0, valid_out}, 64'd1);
    check({tag, "_res"}, {32'd0, result}, {32'd0, exp_res});
    check({tag, "_sp"},  {60'd0, stencil_pass}, {60'd0, exp_sp});
    check({tag, "_lm"},  {60'd0, lane_mask_out}, {60'd0, lm});
    check({tag, "_tag"}, {56'd0, tag_out}, {56'd0, t});
  endtask

  initial begin
    int next_tag, exp_tag, done_cyc;
    logic [7:0] e;
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    func = 3'd7; sfail_op = 3'd0; zfail_op = 3'd0; zpass_op = 3'd0;
    sref = '0; read_mask = 8'hFF; write_mask = 8'hFF;
    lane_mask = 4'hF; depth_pass = 4'hF; val = '0; tag_in = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_vld", {63'd0, valid_out}, 64'd0);
    check("rst_res", {32'd0, result}, 64'd0);
    check("rst_tag", {56'd0, tag_out}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", {63'd0, ready_in}, 64'd1);

    // Test 1: ALWAYS/INCR saturating.
    run_vec("incr", 3'd7, 3'd0, 3'd0, 3'd3, 8'h00, 8'hFF, 8'hFF, 4'hF, 4'hF,
            32'h1000FFFE, 32'h1101FFFF, 4'b1111);
    // Test 2: LESS with read mask, sfail ZERO, zpass REPLACE.
    run_vec("less", 3'd1, 3'd1, 3'd0, 3'd2, 8'h05, 8'h0F, 8'hFF, 4'hF, 4'hF,
            32'hF7140536, 32'h05000005, 4'b1001);
    // Test 3: EQUAL, zfail DECR_WRAP, zpass INVERT, per-lane depth.
    run_vec("equal", 3'd2, 3'd0, 3'd7, 3'd5, 8'h05, 8'hFF, 8'hFF, 4'hF, 4'b0101,
            32'h05050505, 32'h04FA04FA, 4'b1111);
    // Test 4: write mask merge with inactive lanes.
    run_vec("wmask", 3'd7, 3'd0, 3'd0, 3'd1, 8'h00, 8'hFF, 8'hF0, 4'b0010, 4'hF,
            32'hABABABAB, 32'hABAB0BAB, 4'b0010);
    // Test 5: NEVER, sfail DECR saturating at zero.
    run_vec("never", 3'd0, 3'd4, 3'd0, 3'd0, 8'h00, 8'hFF, 8'hFF, 4'hF, 4'hF,
            32'hFF800100, 32'hFE7F0000, 4'b0000);
    // Test 6: GEQUAL, sfail INCR_WRAP, zpass DECR_WRAP.
    run_vec("gequal", 3'd6, 3'd6, 3'd0, 3'd7, 8'h80, 8'hFF, 8'hFF, 4'hF, 4'hF,
            32'h00FF8081, 32'hFF007F82, 4'b1010);
    // Test 7: zfail INCR saturating.
    run_vec("zfail", 3'd7, 3'd0, 3'd3, 3'd0, 8'h00, 8'h00, 8'hFF, 4'hF, 4'h0,
            32'h00FF7FFE, 32'h01FF80FF, 4'b1111);
    @(posedge clk); #1;

    // Streaming: tags 1..6 back to back; ready_out is low in cycles 3..5.
    // Each lane holds tag*0x11 and INCR_WRAP adds one.
    func = 3'd7; zpass_op = 3'd6; sfail_op = 3'd0; zfail_op = 3'd0;
    read_mask = 8'hFF; write_mask = 8'hFF; lane_mask = 4'hF; depth_pass = 4'hF;
    next_tag = 1; exp_tag = 1; done_cyc = 0;
    for (int cyc = 1; cyc <= 30 && exp_tag <= 6; cyc++) begin
      valid_in  = (next_tag <= 6);
      tag_in    = 8'(next_tag);
      e         = 8'(next_tag * 17);
      val       = {4{e}};
      ready_out = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) check("strm_rdy_stall", {63'd0, ready_in}, 64'd0);
      if (cyc == 6) check("strm_rdy_resume", {63'd0, ready_in}, 64'd1);
      if (cyc >= 3) begin
        check("strm_vld", {63'd0, valid_out}, 64'd1);
        check("strm_tag", {56'd0, tag_out}, 64'(exp_tag));
        e = 8'(exp_tag * 17 + 1);
        check("strm_res", {32'd0, result}, {32'd0, {4{e}}});
      end
      if (valid_out && ready_out) begin
        exp_tag++;
        done_cyc = cyc;
      end
      if (valid_in && ready_in) next_tag++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0; ready_out = 1'b1;
    check("strm_count", 64'(exp_tag), 64'd7);
    check("strm_cycles", 64'(done_cyc), 64'd11);
    @(posedge clk); #1;
    check("strm_drain", {63'd0, valid_out}, 64'd0);

    // Reset with two transactions in flight.
    func = 3'd7; zpass_op = 3'd3; val = 32'h01020304;
    valid_in = 1'b1; tag_in = 8'hA1;
    @(posedge clk); #1;
    tag_in = 8'hA2;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("rst2_pre_vld", {63'd0, valid_out}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst2_vld", {63'd0, valid_out}, 64'd0);
    check("rst2_res", {32'd0, result}, 64'd0);
    check("rst2_sp",  {60'd0, stencil_pass}, 64'd0);
    check("rst2_lm",  {60'd0, lane_mask_out}, 64'd0);
    check("rst2_tag", {56'd0, tag_out}, 64'd0);
    @(negedge clk); reset = 1'b1;
    #1;
    check("rst2_rdy", {63'd0, ready_in}, 64'd1);
`ifdef ROP_STENCIL_STATS_EN
    check("stat_pass0", {32'd0, perf_pass_count}, 64'd0);
    check("stat_fail0", {32'd0, perf_fail_count}, 64'd0);
`endif
    @(posedge clk); #1;
    check("rst2_empty", {63'd0, valid_out}, 64'd0);
    run_vec("post_rst", 3'd1, 3'd1, 3'd0, 3'd2, 8'h05, 8'h0F, 8'hFF, 4'hF, 4'hF,
            32'hF7140536, 32'h05000005, 4'b1001);
    @(posedge clk); #1;
    check("post_rst_alone", {63'd0, valid_out}, 64'd0);
`ifdef ROP_STENCIL_STATS_EN
    check("stat_pass1", {32'd0, perf_pass_count}, 64'd2);
    check("stat_fail1", {32'd0, perf_fail_count}, 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
